// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator for a small ALU datapath (add/sub, compare, AND). It takes one command
// at a time from a valid/ready stream and registers the select and operand lines.
// It waits a fixed settle time, captures the result for the selected op, and holds
// that result on a valid/ready response stream until the consumer takes it.
module alu_cmd_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // command stream
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    // ALU select / operand drive
    output logic             alu_s1,
    output logic             alu_s0,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    // ALU results
    input  logic [WIDTH:0]   alu_sum,
    input  logic [WIDTH-1:0] alu_and,
    input  logic             alu_eq,
    input  logic             alu_gt,
    input  logic             alu_lt,
    // response stream
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_op,
    output logic [WIDTH:0]   rsp_data,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    // The counter is loaded with SETTLE_CYCLES-1 on accept and counts down to zero.
    // It must be at least one bit wide, even when SETTLE_CYCLES is 1.
    localparam int              SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]     op;
        logic [WIDTH:0] data;
        logic [2:0]     flags;
        logic           err;
    } rsp_t;

    state_t          state;
    logic [SC_W-1:0] settle_cnt;
    logic [1:0]      op_q;
    rsp_t            rsp_q;
    rsp_t            rsp_cap;
    logic [2:0]      cmp_flags;
    logic            cmp_onehot;

    assign rsp_op    = rsp_q.op;
    assign rsp_data  = rsp_q.data;
    assign rsp_flags = rsp_q.flags;
    assign rsp_err   = rsp_q.err;

    // Pick the result that belongs to the in-flight op from the settled ALU outputs.
    // A comparator whose flags are not exactly one-hot is reported as an error.
    always_comb begin
        cmp_flags  = {alu_gt, alu_eq, alu_lt};
        cmp_onehot = (cmp_flags == 3'b001) || (cmp_flags == 3'b010) || (cmp_flags == 3'b100);
        rsp_cap    = '0;
        rsp_cap.op = op_q;
        case (op_q)
            OP_ADD, OP_SUB: rsp_cap.data = alu_sum;
            OP_AND:         rsp_cap.data = {1'b0, alu_and};
            default: begin
                rsp_cap.flags = cmp_flags;
                rsp_cap.err   = ~cmp_onehot;
            end
        endcase
    end

    // Sequencer FSM: accept -> settle -> respond, with one command in flight.
    // All outputs are registered. cmd_ready stays low while reset is asserted and
    // rises on the first clock edge in IDLE after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            op_q       <= '0;
            cmd_ready  <= 1'b0;
            alu_s1     <= 1'b0;
            alu_s0     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_q      <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        {alu_s1, alu_s0} <= cmd_op;
                        alu_a            <= cmd_a;
                        alu_b            <= cmd_b;
                        op_q             <= cmd_op;
                        settle_cnt       <= SC_LOAD;
                        cmd_ready        <= 1'b0;
                        state            <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        rsp_q     <= rsp_cap;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - SC_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_count != '1) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. It drives two instances: index 0 with SETTLE_CYCLES=1
// and index 1 with SETTLE_CYCLES=3. Each instance has its own behavioural ALU.
// A latency-count reference model is checked against the DUT on every falling edge.
// Directed tests also check hand-computed literal results.
module tb_alu_cmd_sequencer;
    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     [2];
    logic         cmd_valid [2];
    logic         cmd_ready [2];
    logic [1:0]   cmd_op    [2];
    logic [W-1:0] cmd_a     [2];
    logic [W-1:0] cmd_b     [2];
    logic         alu_s1    [2];
    logic         alu_s0    [2];
    logic [W-1:0] alu_a     [2];
    logic [W-1:0] alu_b     [2];
    logic [W:0]   alu_sum   [2];
    logic [W-1:0] alu_and   [2];
    logic         alu_eq    [2];
    logic         alu_gt    [2];
    logic         alu_lt    [2];
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic [1:0]   rsp_op    [2];
    logic [W:0]   rsp_data  [2];
    logic [2:0]   rsp_flags [2];
    logic         rsp_err   [2];
    logic [7:0]   op_count  [2];
    logic         force_bad [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        alu_cmd_sequencer #(.WIDTH(W), .SETTLE_CYCLES(g == 0 ? 1 : 3), .CNT_W(8)) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op[g]),
            .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]),
            .alu_s1(alu_s1[g]), .alu_s0(alu_s0[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
            .alu_sum(alu_sum[g]), .alu_and(alu_and[g]),
            .alu_eq(alu_eq[g]), .alu_gt(alu_gt[g]), .alu_lt(alu_lt[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_op(rsp_op[g]),
            .rsp_data(rsp_data[g]), .rsp_flags(rsp_flags[g]), .rsp_err(rsp_err[g]),
            .op_count(op_count[g])
        );
        // Behavioural ALU: S0 selects subtract. force_bad breaks the comparator.
        assign alu_sum[g] = alu_s0[g] ? ({1'b0, alu_a[g]} - {1'b0, alu_b[g]})
                                      : ({1'b0, alu_a[g]} + {1'b0, alu_b[g]});
        assign alu_and[g] = alu_a[g] & alu_b[g];
        assign alu_eq[g]  = force_bad[g] ? 1'b1 : (alu_a[g] == alu_b[g]);
        assign alu_gt[g]  = force_bad[g] ? 1'b1 : (alu_a[g] >  alu_b[g]);
        assign alu_lt[g]  = force_bad[g] ? 1'b0 : (alu_a[g] <  alu_b[g]);
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    // Expected {err, flags[2:0], data[4:0]} from the op definitions in plain arithmetic.
    function automatic logic [8:0] calc(input logic [1:0] op, input int a, input int b, input logic fb);
        int d, gt, eq, lt;
        logic [4:0] dv;
        logic [2:0] fl;
        logic er;
        d = 0; fl = 3'b000; er = 1'b0;
        case (op)
            2'b00: d = (a + b) & 31;
            2'b01: d = (a - b) & 31;
            2'b11: d = a & b;
            default: begin
                gt = fb ? 1 : (a > b ? 1 : 0);
                eq = fb ? 1 : (a == b ? 1 : 0);
                lt = fb ? 0 : (a < b ? 1 : 0);
                fl = {gt[0], eq[0], lt[0]};
                er = (gt + eq + lt) != 1;
            end
        endcase
        dv = d[4:0];
        return {er, fl, dv};
    endfunction

    // Reference model state, one entry per instance.
    bit         m_ready [2];
    bit         m_vld   [2];
    int         m_wait  [2];
    int         m_cnt   [2];
    logic [1:0] m_sop   [2];
    logic [3:0] m_a     [2];
    logic [3:0] m_b     [2];
    logic [8:0] m_rsp   [2];

    // The model is compared on the falling edge, then advanced to the next rising edge.
    // Inputs only change just after a rising edge, so their current values are the
    // values the DUT will sample on that edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                m_ready[i] = 0; m_vld[i] = 0; m_wait[i] = 0; m_cnt[i] = 0;
                m_sop[i] = 0; m_a[i] = 0; m_b[i] = 0; m_rsp[i] = 0;
            end
            chk("mdl_cmd_ready", i, 32'(cmd_ready[i]), 32'(m_ready[i]));
            chk("mdl_rsp_valid", i, 32'(rsp_valid[i]), 32'(m_vld[i]));
            chk("mdl_op_count",  i, 32'(op_count[i]),  32'(m_cnt[i]));
            chk("mdl_alu_sel",   i, 32'({alu_s1[i], alu_s0[i]}), 32'(m_sop[i]));
            chk("mdl_alu_ab",    i, 32'({alu_a[i], alu_b[i]}),   32'({m_a[i], m_b[i]}));
            if (m_vld[i]) begin
                chk("mdl_rsp_op",  i, 32'(rsp_op[i]), 32'(m_sop[i]));
                chk("mdl_rsp_res", i, 32'({rsp_err[i], rsp_flags[i], rsp_data[i]}), 32'(m_rsp[i]));
            end
            if (rst_n[i]) begin
                if (m_vld[i]) begin
                    if (rsp_ready[i]) begin
                        m_vld[i] = 0; m_ready[i] = 1;
                        if (m_cnt[i] < 255) m_cnt[i]++;
                    end
                end else if (m_wait[i] > 0) begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) m_vld[i] = 1;
                end else if (m_ready[i]) begin
                    if (cmd_valid[i]) begin
                        m_ready[i] = 0;
                        m_sop[i] = cmd_op[i]; m_a[i] = cmd_a[i]; m_b[i] = cmd_b[i];
                        m_rsp[i] = calc(cmd_op[i], int'(cmd_a[i]), int'(cmd_b[i]), force_bad[i]);
                        m_wait[i] = (i == 0) ? 1 : 3;
                    end
                end else begin
                    m_ready[i] = 1;
                end
            end
        end
    end

    // Holds cmd_valid until the handshake edge. Returns just after the accept edge.
    task automatic wait_accept(input int i);
        bit ok;
        ok = 0;
        cmd_valid[i] = 1'b1;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_ready[i];
            @(posedge clk); #1;
        end
        chk("accept_timeout", i, 32'(ok), 32'd1);
    endtask

    // Runs one command through with rsp_ready=1.
    // Checks the literal result and the accept-to-valid latency.
    task automatic do_cmd(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [4:0] ed, input logic [2:0] ef, input logic ee, input int el);
        int  lat;
        bit  ok;
        cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b; rsp_ready[i] = 1'b1;
        wait_accept(i);
        cmd_valid[i] = 1'b0;
        lat = 0; ok = 0;
        while (!ok && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            ok = rsp_valid[i];
        end
        chk("latency",   i, 32'(lat), 32'(el));
        chk("rsp_data",  i, 32'(rsp_data[i]),  32'(ed));
        chk("rsp_flags", i, 32'(rsp_flags[i]), 32'(ef));
        chk("rsp_err",   i, 32'(rsp_err[i]),   32'(ee));
        @(posedge clk); #1;
        chk("rsp_drop",  i, 32'(rsp_valid[i]), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_op[i] = 2'b00; cmd_a[i] = '0; cmd_b[i] = '0;
            rsp_ready[i] = 1'b0; force_bad[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_cmd_ready", 0, 32'(cmd_ready[0]), 32'd0);
        chk("rst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("rst_op_count",  0, 32'(op_count[0]),  32'd0);
        chk("rst_alu",       0, 32'({alu_s1[0], alu_s0[0], alu_a[0], alu_b[0]}), 32'd0);
        chk("rst_rsp",       0, 32'({rsp_op[0], rsp_data[0], rsp_flags[0], rsp_err[0]}), 32'd0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 0, 32'(cmd_ready[0]), 32'd1);

        // Case 1: ADD with single-cycle settle
        do_cmd(0, 2'b00, 4'b0001, 4'b1000, 5'b01001, 3'b000, 1'b0, 1);
        chk("op_count_1", 0, 32'(op_count[0]), 32'd1);
        // Case 2: carry out of ADD, then SUB wrapping negative
        do_cmd(0, 2'b00, 4'b1111, 4'b1111, 5'b11110, 3'b000, 1'b0, 1);
        do_cmd(0, 2'b01, 4'b0011, 4'b0101, 5'b11110, 3'b000, 1'b0, 1);
        // Case 3: compare outcomes
        do_cmd(0, 2'b10, 4'b0101, 4'b0101, 5'b00000, 3'b010, 1'b0, 1);
        do_cmd(0, 2'b10, 4'b1111, 4'b1110, 5'b00000, 3'b100, 1'b0, 1);
        do_cmd(0, 2'b10, 4'b1110, 4'b1111, 5'b00000, 3'b001, 1'b0, 1);
        // Case 4: AND, then a broken comparator reporting gt and eq together
        do_cmd(0, 2'b11, 4'b0111, 4'b1110, 5'b00110, 3'b000, 1'b0, 1);
        force_bad[0] = 1'b1;
        do_cmd(0, 2'b10, 4'b0011, 4'b0011, 5'b00000, 3'b110, 1'b1, 1);
        force_bad[0] = 1'b0;
        chk("op_count_8", 0, 32'(op_count[0]), 32'd8);

        // Case 5: hold the response with backpressure while a second command waits
        rsp_ready[0] = 1'b0;
        cmd_op[0] = 2'b00; cmd_a[0] = 4'd2; cmd_b[0] = 4'd3;
        wait_accept(0);
        cmd_op[0] = 2'b11; cmd_a[0] = 4'b1100; cmd_b[0] = 4'b1010;
        @(posedge clk); #1;
        chk("bp_valid", 0, 32'(rsp_valid[0]), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_data",  0, 32'(rsp_data[0]),  32'd5);
            chk("bp_hold_ready", 0, 32'(cmd_ready[0]), 32'd0);
            chk("bp_hold_alu_a", 0, 32'(alu_a[0]),     32'd2);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("bp_hs_alu_a", 0, 32'(alu_a[0]),     32'd2);
        @(posedge clk); #1;
        chk("bp_acc_alu_a", 0, 32'(alu_a[0]),     32'b1100);
        chk("bp_acc_ready", 0, 32'(cmd_ready[0]), 32'd0);
        cmd_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("bp2_data", 0, 32'(rsp_data[0]), 32'b01000);
        @(posedge clk); #1;
        chk("op_count_10", 0, 32'(op_count[0]), 32'd10);

        // op_count saturation: back-to-back commands with no stalls
        cmd_op[0] = 2'b00; cmd_a[0] = 4'd1; cmd_b[0] = 4'd1; cmd_valid[0] = 1'b1;
        repeat (800) @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("op_count_sat", 0, 32'(op_count[0]), 32'd255);

        // Case 6: three-cycle settle, reset during SETTLE, then a clean rerun
        do_cmd(1, 2'b00, 4'b0001, 4'b1000, 5'b01001, 3'b000, 1'b0, 3);
        chk("s3_op_count", 1, 32'(op_count[1]), 32'd1);
        cmd_op[1] = 2'b01; cmd_a[1] = 4'd5; cmd_b[1] = 4'd6;
        wait_accept(1);
        cmd_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        chk("midrst_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        chk("midrst_alu",       1, 32'({alu_s1[1], alu_s0[1], alu_a[1], alu_b[1]}), 32'd0);
        chk("midrst_op_count",  1, 32'(op_count[1]),  32'd0);
        chk("midrst_cmd_ready", 1, 32'(cmd_ready[1]), 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;
        do_cmd(1, 2'b00, 4'b0001, 4'b1000, 5'b01001, 3'b000, 1'b0, 3);
        chk("rerun_op_count", 1, 32'(op_count[1]), 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
